// File: rtl/wb_openram_arbiter_pkg.sv
// wb_oram_pkg: shared types and constants for the OpenRAM Wishbone arbiter.
//   state_t        - controller states (IDLE, MEM, RD, ACK, ERR)
//   PORT_A/PORT_B  - port identifiers used for grant and write ownership
//   ACCESS_LATENCY - cycles from request seen to ack
//   port_onehot()  - port id to one-hot grant vector
package wb_oram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MEM  = 3'd1,
        RD   = 3'd2,
        ACK  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int ACCESS_LATENCY = 3;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_openram_arbiter_if.sv
// wb_openram_arbiter_if: one classic (non-pipelined) Wishbone slave port.
//   master -> slave : stb, cyc, we, sel, adr (byte address), wdat
//   slave -> master : ack, err, rdat
// Handshake: a request is valid while stb & cyc are both high; it is
// accepted and completed by exactly one cycle of ack (or err). The master
// holds all request fields stable until that cycle and drops stb after it.
// Dropping cyc before ack abandons the request; no ack is then returned.
interface wb_openram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  stb;
    logic                  cyc;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [ADDR_WIDTH+1:0] adr;
    logic [DATA_WIDTH-1:0] wdat;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdat;

    modport master (output stb, cyc, we, sel, adr, wdat, input ack, err, rdat);
    modport slave  (input stb, cyc, we, sel, adr, wdat, output ack, err, rdat);
endinterface

// File: rtl/wb_openram_arbiter_rr.sv
// rr_arbiter_2: two-requester round-robin arbiter.
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_a, req_b - requests
//   en           - arbitration allowed this cycle; grant is 00 otherwise
//   grant        - one-hot winner, combinational ({B, A})
//   last_grant   - port that won the most recent enabled arbitration
// After reset last_grant is B, so A wins the first tie.
module rr_arbiter_2
    import wb_oram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       en,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req_a && req_b) begin
                // Tie goes to whichever port did not win last time.
                grant = (last_grant == PORT_B) ? 2'b01 : 2'b10;
            end else if (req_a) begin
                grant = 2'b01;
            end else if (req_b) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
        end else if (grant != 2'b00) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/wb_openram_arbiter.sv
// wb_openram_arbiter: shares port 0 (rw) of the OpenRAM 32x256 macro between
// two Wishbone slave ports (A: caravel bridge, B: user rambus).
//   wb_clk_i, wb_rst_n_i - clock, asynchronous active-low reset
//   wr_owner_i           - port allowed to write (0=A, 1=B), sampled at grant
//   wbs_a, wbs_b         - Wishbone slave ports
//   ram_*0               - OpenRAM port 0 (active-low csb/web)
//   grant_o              - one-hot current owner, 00 when idle
//   state_o              - controller state
// Sequence: grant in IDLE (cycle 0), MEM drives the SRAM (cycle 1), RD
// captures read data (cycle 2), ACK terminates (cycle 3). A write from the
// non-owner goes to ERR instead and never touches the SRAM.
module wb_openram_arbiter
    import wb_oram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    wr_owner_i,
    wb_openram_arbiter_if.slave     wbs_a,
    wb_openram_arbiter_if.slave     wbs_b,
    output logic                    ram_clk0,
    output logic                    ram_csb0,
    output logic                    ram_web0,
    output logic [SEL_WIDTH-1:0]    ram_wmask0,
    output logic [ADDR_WIDTH-1:0]   ram_addr0,
    output logic [DATA_WIDTH-1:0]   ram_din0,
    input  logic [DATA_WIDTH-1:0]   ram_dout0,
    output logic [1:0]              grant_o,
    output state_t                  state_o
);

    state_t                state, state_nxt;
    logic [1:0]            arb_grant;
    logic                  last_grant;
    logic                  win;
    logic                  win_we;
    logic                  req_port;
    logic                  req_we;
    logic [SEL_WIDTH-1:0]  req_sel;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_dat;
    logic [DATA_WIDTH-1:0] dat_a_q, dat_b_q;
    logic [1:0]            grant_q;
    logic                  unused_adr_lsb;

    // Word addressing: byte-lane bits of the Wishbone address are dropped.
    assign unused_adr_lsb = ^{wbs_a.adr[1:0], wbs_b.adr[1:0], last_grant};

    rr_arbiter_2 u_arb (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .req_a      (wbs_a.stb && wbs_a.cyc),
        .req_b      (wbs_b.stb && wbs_b.cyc),
        .en         (state == IDLE),
        .grant      (arb_grant),
        .last_grant (last_grant)
    );

    assign win    = arb_grant[1];
    assign win_we = win ? wbs_b.we : wbs_a.we;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_grant != 2'b00) begin
                    state_nxt = (win_we && (win != wr_owner_i)) ? ERR : MEM;
                end
            end
            MEM:     state_nxt = RD;
            RD:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            req_port <= PORT_A;
            req_we   <= 1'b0;
            req_sel  <= '0;
            req_addr <= '0;
            req_dat  <= '0;
            grant_q  <= 2'b00;
            dat_a_q  <= '0;
            dat_b_q  <= '0;
        end else begin
            if (state == IDLE && arb_grant != 2'b00) begin
                req_port <= win;
                req_we   <= win_we;
                req_sel  <= win ? wbs_b.sel : wbs_a.sel;
                req_addr <= win ? wbs_b.adr[ADDR_WIDTH+1:2] : wbs_a.adr[ADDR_WIDTH+1:2];
                req_dat  <= win ? wbs_b.wdat : wbs_a.wdat;
                grant_q  <= port_onehot(win);
            end else if (state == ACK || state == ERR) begin
                grant_q <= 2'b00;
            end
            // SRAM output is valid during RD, one cycle after the MEM edge.
            if (state == RD && !req_we) begin
                if (req_port == PORT_A) begin
                    dat_a_q <= ram_dout0;
                end else begin
                    dat_b_q <= ram_dout0;
                end
            end
        end
    end

    assign ram_clk0   = wb_clk_i;
    assign ram_csb0   = (state != MEM);
    assign ram_web0   = !((state == MEM) && req_we);
    assign ram_wmask0 = ((state == MEM) && req_we) ? req_sel : '0;
    assign ram_addr0  = req_addr;
    assign ram_din0   = req_dat;

    // Ack is withheld when the master has abandoned the cycle.
    assign wbs_a.ack  = (state == ACK) && (req_port == PORT_A) && wbs_a.cyc;
    assign wbs_b.ack  = (state == ACK) && (req_port == PORT_B) && wbs_b.cyc;
    assign wbs_a.err  = (state == ERR) && (req_port == PORT_A);
    assign wbs_b.err  = (state == ERR) && (req_port == PORT_B);
    assign wbs_a.rdat = dat_a_q;
    assign wbs_b.rdat = dat_b_q;

    assign grant_o = grant_q;
    assign state_o = state;

endmodule
